// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants for the sync generator and the graphics blocks.
// The 10-bit copies let counter comparisons stay width-matched.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;

    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    // True when count lies in the inclusive window [first, last].
    function automatic logic in_window(input logic [9:0] count,
                                       input logic [9:0] first,
                                       input logic [9:0] last);
        return (count >= first) && (count <= last);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle from the sync generator to its consumers.
// p_tick qualifies the pixel: consumers sample pixel_x/pixel_y and drive RGB only when it is high.
interface vga_sync_if;

    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       f_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        output hsync, vsync, video_on, p_tick, f_tick, pixel_x, pixel_y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, f_tick, pixel_x, pixel_y
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel enable every TICK_DIV clocks.
module pixel_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] DIV_LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div;

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// 640x480 VGA raster generator: pixel/line counters plus registered active-low syncs.
// Syncs are registered from the next-count values so they move in the same clk as pixel_x/pixel_y.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    vga_sync_if.master  vga
);

    logic       p_tick;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_q;
    logic       vsync_q;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
    end

    // Reset wins over counting, so a mid-line reset never leaves a partial sync pulse behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            hsync_q <= !in_window(h_next, H_SYNC_FIRST, H_SYNC_LAST);
            vsync_q <= !in_window(v_next, V_SYNC_FIRST, V_SYNC_LAST);
        end
    end

    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.p_tick   = p_tick;
    assign vga.pixel_x  = h_count;
    assign vga.pixel_y  = v_count;
    assign vga.video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
    assign vga.f_tick   = p_tick && (h_count == H_LAST) && (v_count == V_LAST);

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, system clocks per pixel (100 MHz clk -> 25 MHz pixel rate); legal range 2..8.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high; one clock, no other clock domains.
REQ-004 SHALL have port hsync  output  1  horizontal sync, active-low, registered.
REQ-005 SHALL have port vsync  output  1  vertical sync, active-low, registered.
REQ-006 SHALL have port video_on  output  1  high only while (pixel_x, pixel_y) lies in the 640x480 visible area.
REQ-007 SHALL have port p_tick  output  1  one-clk pulse per pixel period; consumers sample pixel_x/pixel_y and drive RGB on it.
REQ-008 SHALL have port pixel_x  output  10  current horizontal count, 0..799.
REQ-009 SHALL have port pixel_y  output  10  current vertical count, 0..524.
REQ-010 SHALL have port f_tick  output  1  one-clk pulse marking the start of a frame (counts wrapping to 0,0).

Function
REQ-011 SHALL hold a divide counter 0..TICK_DIV-1 that increments every clk and wraps to 0; p_tick = (div == TICK_DIV-1).
REQ-012 SHALL advance h_count only on p_tick; 799 -> 0 wrap, otherwise +1.
REQ-013 SHALL advance v_count only on p_tick with h_count == 799; 524 -> 0 wrap, otherwise +1; v_count holds otherwise.
REQ-014 SHALL use horizontal timing 640 display, 16 front porch, 96 sync, 48 back porch (total 800).
REQ-015 SHALL use vertical timing 480 display, 10 front porch, 2 sync, 33 back porch (total 525).
REQ-016 SHALL register hsync = 0 exactly while h_count in 656..751 inclusive, computed from next-count values so hsync changes in the same clk as pixel_x.
REQ-017 SHALL register vsync = 0 exactly while v_count in 490..491 inclusive, aligned to pixel_y as in REQ-016.
REQ-018 SHALL drive video_on = (h_count < 640) && (v_count < 480), combinational from registered counts; zero latency to pixel_x/pixel_y.
REQ-019 SHALL drive pixel_x = h_count and pixel_y = v_count directly from registers.
REQ-020 SHALL assert f_tick for one clk when p_tick && h_count == 799 && v_count == 524.
REQ-021 SHALL keep counts constant between p_ticks (TICK_DIV-1 clks of hold).
REQ-022 SHALL never present h_count > 799 or v_count > 524, including immediately after reset.

Reset
REQ-023 SHALL, on reset high at a clk edge, set div = 0, h_count = 0, v_count = 0, hsync = 1, vsync = 1.
REQ-024 SHALL therefore output video_on = 1, p_tick = 0, f_tick = 0 during and directly after reset.
REQ-025 SHALL have reset priority over counting; reset mid-line or mid-frame restarts at (0,0) with no partial sync pulse.
REQ-026 SHALL produce the first p_tick TICK_DIV-1 clks after reset deasserts.

Structure
REQ-027 SHALL take H_DISPLAY, H_FP, H_SYNC, H_BP, V_DISPLAY, V_FP, V_SYNC, V_BP and derived H_TOTAL/V_TOTAL from shared package vga_timing_pkg, also used by graphics blocks.
REQ-028 SHALL implement the divider as sub-module pixel_tick_gen (parameter TICK_DIV; ports clk, reset, p_tick).
REQ-029 SHALL contain no other sub-modules; counters and sync registers are local.

Verification
REQ-030 Reset then run 4 clks -> p_tick high on clk 3 only, pixel_x 0->1 after it, hsync = vsync = 1, video_on = 1.
REQ-031 Run one line (3200 clks) -> video_on low for pixel_x 640..799, hsync low for exactly 96 p_ticks starting at pixel_x 656, pixel_y 0->1 at wrap.
REQ-032 Run one frame (1,680,000 clks) -> vsync low exactly for pixel_y 490..491 (1600 p_ticks), single f_tick at wrap to (0,0), pixel_y max 524.
REQ-033 Assert reset at pixel_x 700 (inside hsync) -> next clk pixel_x = 0, pixel_y = 0, hsync = 1, no f_tick.
REQ-034 Parameter TICK_DIV = 2 -> p_tick every 2nd clk, line length 1600 clks, same sync widths in p_ticks.
REQ-035 Two consecutive frames -> f_tick spacing exactly 420,000 p_ticks; counts never exceed 799/524 (assertion).
